// File: rtl/mips_pkg.sv
// Shared MIPS opcode constants and fetch FSM state encoding.
// Later pipeline stages import this package alongside instr_decode.
package mips_pkg;
    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_JAL = 6'h03;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05;

    localparam int WAIT_W = 5;

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, ERROR} fetch_state_e;
endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction-memory read channel between the fetch unit (master) and the memory (slave).
interface instruction_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, imem_addr, input  imem_ack, imem_rdata);
    modport slave  (input  imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/instr_decode.sv
// Combinational branch/jump decode of a latched instruction word.
module instr_decode
    import mips_pkg::*;
(
    input  logic [31:0] instr_i,
    input  logic        instr_valid_i,
    input  logic        regs_equal_i,
    output logic        branch_select_o,
    output logic        jump_enable_o,
    output logic [31:0] sign_extended_immediate_o,
    output logic [25:0] jump_address_o
);
    logic [5:0] opcode;
    logic       is_jump;
    logic       is_branch;

    assign opcode    = instr_i[31:26];
    assign is_jump   = (opcode == OP_J) || (opcode == OP_JAL);
    assign is_branch = ((opcode == OP_BEQ) &&  regs_equal_i) ||
                       ((opcode == OP_BNE) && !regs_equal_i);

    // A jump always wins over a branch decode.
    assign jump_enable_o   = instr_valid_i && is_jump;
    assign branch_select_o = instr_valid_i && is_branch && !is_jump;

    assign sign_extended_immediate_o = {{16{instr_i[15]}}, instr_i[15:0]};
    assign jump_address_o            = instr_i[25:0];
endmodule

// File: rtl/instruction_fetch.sv
// Fetch unit: requests the word at pc, latches it, holds it until the next stage
// accepts, and locks into ERROR on a misaligned pc or a memory that never answers.
module instruction_fetch
    import mips_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [31:0]                pc,
    input  logic                       regs_equal,
    instruction_fetch_if.master        imem,
    output logic [31:0]                instr,
    output logic                       instr_valid,
    input  logic                       instr_ready,
    output logic                       pc_advance,
    output logic                       branch_select,
    output logic                       jump_enable,
    output logic [31:0]                sign_extended_immediate,
    output logic [25:0]                jump_address,
    output logic                       fetch_error
);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    fetch_state_e      state_q, state_d;
    logic [31:0]       instr_q, instr_d;
    logic [WAIT_W-1:0] wait_q,  wait_d;
    logic              aligned;
    logic              req;
    logic              valid;
    logic              adv;

    assign aligned = (pc[1:0] == 2'b00);

    // reset_n is active-high despite its name.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state_q <= IDLE;
            instr_q <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        wait_d  = wait_q;
        req     = 1'b0;
        valid   = 1'b0;
        adv     = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
                wait_d  = '0;
            end
            FETCH: begin
                if (!aligned) begin
                    state_d = ERROR;
                end else begin
                    req = 1'b1;
                    if (imem.imem_ack) begin
                        instr_d = imem.imem_rdata;
                        state_d = HOLD;
                    end else if (wait_q == WAIT_LAST) begin
                        state_d = ERROR;
                    end else begin
                        wait_d = wait_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                valid = 1'b1;
                if (instr_ready) begin
                    adv     = 1'b1;
                    wait_d  = '0;
                    state_d = FETCH;
                end
            end
            ERROR:   ;
            default: state_d = IDLE;
        endcase
    end

    // Gate with reset so the request drops the instant reset rises.
    assign imem.imem_req  = req && !reset_n;
    assign imem.imem_addr = pc;
    assign instr          = instr_q;
    assign instr_valid    = valid;
    assign pc_advance     = adv;
    assign fetch_error    = (state_q == ERROR);

    instr_decode u_decode (
        .instr_i                   (instr_q),
        .instr_valid_i             (valid),
        .regs_equal_i              (regs_equal),
        .branch_select_o           (branch_select),
        .jump_enable_o             (jump_enable),
        .sign_extended_immediate_o (sign_extended_immediate),
        .jump_address_o            (jump_address)
    );
endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 16: the maximum number of FETCH cycles without imem_ack before an error.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-high reset (1 = in reset).
REQ-004 The block SHALL have port pc, input, 32 bits: the current program counter from the PC register.
REQ-005 The block SHALL have port regs_equal, input, 1 bit: the rs == rt compare result from the register-file read stage.
REQ-006 The block SHALL have port imem_req, output, 1 bit: instruction-memory read request.
REQ-007 The block SHALL have port imem_addr, output, 32 bits: read address, equal to pc.
REQ-008 The block SHALL have port imem_ack, input, 1 bit: the read completed and imem_rdata is valid this cycle.
REQ-009 The block SHALL have port imem_rdata, input, 32 bits: the instruction word read from memory.
REQ-010 The block SHALL have port instr, output, 32 bits: the latched instruction register.
REQ-011 The block SHALL have port instr_valid, output, 1 bit: instr and all decoded outputs are valid.
REQ-012 The block SHALL have port instr_ready, input, 1 bit: the downstream stage accepts instr.
REQ-013 The block SHALL have port pc_advance, output, 1 bit: a one-cycle strobe telling the PC register to load its next value.
REQ-014 The block SHALL have port branch_select, output, 1 bit: branch taken.
REQ-015 The block SHALL have port jump_enable, output, 1 bit: jump taken.
REQ-016 The block SHALL have port sign_extended_immediate, output, 32 bits: the sign-extended instr[15:0].
REQ-017 The block SHALL have port jump_address, output, 26 bits: instr[25:0].
REQ-018 The block SHALL have port fetch_error, output, 1 bit: sticky error flag (timeout or misaligned pc).

Function
REQ-019 The block SHALL implement the FSM states IDLE, FETCH, HOLD and ERROR.
REQ-020 From IDLE, the FSM SHALL go to FETCH on the next clock edge, unconditionally.
REQ-021 In FETCH with pc[1:0] != 0, the block SHALL keep imem_req at 0 and enter ERROR on the next edge.
REQ-022 In FETCH with aligned pc, the block SHALL drive imem_req=1 and imem_addr=pc.
REQ-023 In FETCH, imem_ack=1 SHALL load imem_rdata into instr and move the FSM to HOLD on the same edge; acknowledge in the same cycle as the request is legal.
REQ-024 A 5-bit wait counter SHALL clear on FETCH entry and increment on each FETCH cycle without imem_ack.
REQ-025 When the wait counter reaches TIMEOUT_CYCLES-1 without an ack, the FSM SHALL enter ERROR.
REQ-026 In HOLD, instr_valid SHALL be 1 and instr SHALL be stable.
REQ-027 In HOLD with instr_ready=1, pc_advance SHALL be 1 for exactly that cycle and the FSM SHALL return to FETCH.
REQ-028 The FETCH that follows a HOLD handshake SHALL use the updated pc.
REQ-029 Minimum latency: instr_valid SHALL rise 2 cycles after reset deasserts (IDLE, FETCH, then HOLD), given an immediate ack.
REQ-030 Throughput: with immediate ack and instr_ready held at 1, the block SHALL accept one instruction every 2 cycles.
REQ-031 branch_select SHALL equal instr_valid AND ((opcode==6'h04 AND regs_equal) OR (opcode==6'h05 AND NOT regs_equal)), where opcode = instr[31:26].
REQ-032 jump_enable SHALL equal instr_valid AND (opcode==6'h02 OR opcode==6'h03).
REQ-033 If a jump and a branch are both decoded, jump_enable SHALL take priority; branch_select SHALL be 0 whenever jump_enable=1.
REQ-034 sign_extended_immediate SHALL equal {16 copies of instr[15], instr[15:0]}, and jump_address SHALL equal instr[25:0]; both are combinational from instr.
REQ-035 ERROR SHALL be terminal until reset: fetch_error=1, and imem_req, instr_valid and pc_advance all 0.
REQ-036 A late imem_ack arriving in HOLD or ERROR SHALL be ignored.

Reset
REQ-037 reset_n=1 SHALL asynchronously force: state=IDLE, instr=0, wait counter=0, fetch_error=0.
REQ-038 During reset, all outputs SHALL be 0 (imem_addr still follows pc).
REQ-039 Reset asserted mid-FETCH SHALL drop imem_req immediately, without waiting for a clock edge.

Structure
REQ-040 The opcode constants (BEQ=6'h04, BNE=6'h05, J=6'h02, JAL=6'h03) and the FSM state enum SHALL reside in the shared package mips_pkg.
REQ-041 Decode SHALL be a separate combinational sub-module, instr_decode (instr and regs_equal in, decoded outputs out), reusable by later pipeline stages.

Verification
REQ-042 Scenario: release reset, imem_ack tied 1, pc=0x00000000, imem_rdata=0x1000_0003 (beq, imm=3), regs_equal=1. Required: instr_valid at cycle 2, branch_select=1, sign_extended_immediate=0x00000003.
REQ-043 Scenario: imem_rdata=0x0800_0010 (j). Required: jump_enable=1, jump_address=0x0000010, branch_select=0.
REQ-044 Scenario: bne with imm=0xFFFE and regs_equal=1. Required: branch_select=0, sign_extended_immediate=0xFFFFFFFE.
REQ-045 Scenario: hold instr_ready=0 for 5 cycles in HOLD. Required: instr stable, pc_advance=0 throughout; then instr_ready=1 gives exactly one pc_advance pulse.
REQ-046 Scenario: imem_ack held 0 for 16 cycles. Required: fetch_error=1 and imem_req=0 afterwards. Scenario: pc=0x00000002. Required: ERROR with no imem_req ever asserted.
REQ-047 Scenario: assert reset_n mid-FETCH, between clock edges. Required: imem_req falls immediately; after release, the fetch restarts from IDLE.
